// File: rtl/scan_pkg.sv
// Shared types and constants for the mux scan sequencer: FSM states,
// default frame header bytes and the mux address width.
package scan_pkg;

  localparam int ADDR_W = 6;
  localparam int ADC_W  = 12;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HDR0_DEF     = 8'hAA;
  localparam logic [BYTE_W-1:0] HDR1_DEF     = 8'h55;
  localparam logic [BYTE_W-1:0] TIMEOUT_BYTE = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_SETTLE,
    ST_CONV,
    ST_WAIT,
    ST_PUSH,
    ST_CKSUM,
    ST_DONE
  } state_e;

  // States that own a pending FIFO byte in wr_data.
  function automatic logic is_write_state(input state_e s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_PUSH) || (s == ST_CKSUM);
  endfunction

endpackage

// File: rtl/flag_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// single-cycle falling-edge pulse. Reusable for any front-panel input.
module flag_sync_edge #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: all three flops reset to the idle level of the input, so leaving
  // reset with the line at rest can never fabricate an edge. Sequential state
  // is updated with <= so the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Both operands are flops, so the pulse is glitch-free.
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans one frame across the mux tree: settle, convert, capture, and push
// header + samples + checksum bytes into the UART TX FIFO.
module mux_scan_sequencer
  import scan_pkg::*;
#(
  parameter int          N_CH       = 48,
  parameter int          SETTLE_CYC = 500,
  parameter int          ADC_TO_CYC = 4096,
  parameter logic [7:0]  HDR0       = HDR0_DEF,
  parameter logic [7:0]  HDR1       = HDR1_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flag,
  output logic [ADDR_W-1:0] addr,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              wr_en,
  output logic [BYTE_W-1:0] wr_data,
  input  logic              full,
  output logic              busy,
  output logic              frame_done,
  output logic              to_err
);

  // One down-counter serves both the settle delay and the ADC timeout.
  localparam int CNT_MAX = (SETTLE_CYC > ADC_TO_CYC) ? SETTLE_CYC : ADC_TO_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LD     = CNT_W'(ADC_TO_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_CH   = ADDR_W'(N_CH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   ch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BYTE_W-1:0]   cksum_q;
  logic [BYTE_W-1:0]   wr_data_q;
  logic                adc_start_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                to_err_q;

  logic                start_pulse;
  logic                wr_fire;
  logic [BYTE_W-1:0]   cksum_next;
  logic                unused_adc_lsbs;

  flag_sync_edge #(
    .IDLE_LEVEL (1'b1)
  ) u_flag_sync (
    .clk     (clk),
    .rst_n   (reset_n),
    .async_i (flag),
    .fall_o  (start_pulse)
  );

  // NOTE: wr_en is the only output not taken straight from a flop: it must
  // drop in the same cycle full rises, so the pending byte is gated by full
  // combinationally instead of waiting a clock to notice backpressure.
  assign wr_fire    = is_write_state(state_q) && !full;
  assign cksum_next = cksum_q + wr_data_q;

  // The ADC's four LSBs are below the byte resolution carried in the frame.
  assign unused_adc_lsbs = ^adc_data[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      cnt_q        <= '0;
      cksum_q      <= '0;
      wr_data_q    <= '0;
      adc_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      to_err_q     <= 1'b0;
    end else begin
      adc_start_q  <= 1'b0;
      frame_done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_q   <= ST_HDR0;
            busy_q    <= 1'b1;
            to_err_q  <= 1'b0;
            ch_q      <= '0;
            cksum_q   <= '0;
            wr_data_q <= HDR0;
          end
        end

        ST_HDR0: begin
          if (wr_fire) begin
            state_q   <= ST_HDR1;
            wr_data_q <= HDR1;
          end
        end

        ST_HDR1: begin
          if (wr_fire) begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_LD;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q     <= ST_CONV;
            adc_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_CONV: begin
          state_q <= ST_WAIT;
          cnt_q   <= TO_LD;
        end

        ST_WAIT: begin
          if (adc_done) begin
            state_q   <= ST_PUSH;
            wr_data_q <= adc_data[ADC_W-1 -: BYTE_W];
          end else if (cnt_q == '0) begin
            state_q   <= ST_PUSH;
            wr_data_q <= TIMEOUT_BYTE;
            to_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_PUSH: begin
          if (wr_fire) begin
            cksum_q <= cksum_next;
            if (ch_q == LAST_CH) begin
              state_q   <= ST_CKSUM;
              wr_data_q <= cksum_next;
            end else begin
              state_q <= ST_SETTLE;
              ch_q    <= ch_q + ADDR_W'(1);
              cnt_q   <= SETTLE_LD;
            end
          end
        end

        ST_CKSUM: begin
          if (wr_fire) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          ch_q    <= '0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr       = ch_q;
  assign adc_start  = adc_start_q;
  assign wr_en      = wr_fire;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign to_err     = to_err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: frame-level byte model, ADC
// responder, backpressure, timeout, glitch and mid-frame reset scenarios.
module tb_mux_scan_sequencer;

  localparam int N_CH         = 4;
  localparam int SETTLE_CYC   = 10;
  localparam int ADC_TO_CYC   = 50;
  localparam int ADC_LAT      = 3;
  localparam int FRAME_BUDGET = 3000;
  localparam int FRAME_LEN    = N_CH + 3;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        flag     = 1'b1;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        full     = 1'b0;
  logic [5:0]  addr;
  logic        adc_start;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic        to_err;

  mux_scan_sequencer #(
    .N_CH       (N_CH),
    .SETTLE_CYC (SETTLE_CYC),
    .ADC_TO_CYC (ADC_TO_CYC),
    .HDR0       (8'hAA),
    .HDR1       (8'h55)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flag       (flag),
    .addr       (addr),
    .adc_start  (adc_start),
    .adc_done   (adc_done),
    .adc_data   (adc_data),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .busy       (busy),
    .frame_done (frame_done),
    .to_err     (to_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the frame a correct sequencer must emit
  logic [11:0] adc_tab [N_CH] = '{12'h120, 12'h340, 12'h560, 12'h780};
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          suppress_ch = -1;
  bit          exp_to_err  = 1'b0;
  bit          bp_hdr1_en  = 1'b0;
  bit          bp_push_en  = 1'b0;

  task automatic build_frame(input int skip);
    int         sum;
    logic [7:0] b;
    sum = 0;
    exp_q.delete();
    suppress_ch = skip;
    exp_to_err  = (skip >= 0);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int i = 0; i < N_CH; i++) begin
      b   = (i == skip) ? 8'hFF : 8'(adc_tab[i] / 16);
      sum = (sum + int'(b)) % 256;
      exp_q.push_back(b);
    end
    exp_q.push_back(8'(sum));
  endtask

  // Per-cycle compare process
  int         cyc         = 0;
  int         ref_cyc     = 0;
  int         byte_idx    = 0;
  int         starts      = 0;
  int         frames_done = 0;
  logic [5:0] prev_addr   = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (addr != prev_addr) begin
        ref_cyc   = cyc;
        prev_addr = addr;
      end
      if (wr_en) begin
        check("wr_en_while_full", 32'(full), 32'd0);
        check("busy_during_write", 32'(busy), 32'd1);
        if (byte_idx == 0) begin
          got_q.delete();
          starts = 0;
          check("to_err_clear_at_start", 32'(to_err), 32'd0);
        end
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        got_q.push_back(wr_data);
        byte_idx++;
        if (byte_idx == 2) ref_cyc = cyc + 1;
      end
      if (adc_start) begin
        check("addr_at_conv", 32'(addr), 32'(starts));
        check("settle_cycles", 32'(cyc - ref_cyc), 32'(SETTLE_CYC));
        starts++;
      end
      if (frame_done) begin
        check("frame_len", 32'(byte_idx), 32'(FRAME_LEN));
        check("busy_at_done", 32'(busy), 32'd0);
        check("to_err_at_done", 32'(to_err), 32'(exp_to_err));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        frames_done++;
        byte_idx = 0;
      end
    end
  end

  // ADC responder, plus a stray adc_done that must be ignored outside WAIT
  initial begin
    int ch;
    forever begin
      @(posedge clk); #1;
      if (adc_start && reset_n) begin
        ch = int'(addr);
        if (ch != suppress_ch) begin
          repeat (ADC_LAT - 1) @(posedge clk);
          #1;
          adc_done = 1'b1;
          adc_data = adc_tab[ch];
          if (bp_push_en && ch == 1) full = 1'b1;
          @(posedge clk); #1;
          adc_done = 1'b0;
          adc_data = '0;
          if (bp_push_en && ch == 1) begin
            for (int i = 0; i < 19; i++) begin
              @(negedge clk);
              check("hold_push_data", 32'(wr_data), 32'h34);
              @(posedge clk); #1;
            end
            full       = 1'b0;
            bp_push_en = 1'b0;
          end else begin
            @(posedge clk); #1;
            adc_done = 1'b1;
            adc_data = 12'hABC;
            @(posedge clk); #1;
            adc_done = 1'b0;
            adc_data = '0;
          end
        end
      end
    end
  end

  // Backpressure on the second header byte
  initial begin
    forever begin
      @(negedge clk);
      if (bp_hdr1_en && reset_n && wr_en && wr_data == 8'hAA) begin
        @(posedge clk); #1;
        full = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check("hold_hdr1_data", 32'(wr_data), 32'h55);
        end
        @(posedge clk); #1;
        full       = 1'b0;
        bp_hdr1_en = 1'b0;
      end
    end
  end

  task automatic pulse_flag();
    @(posedge clk); #1;
    flag = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flag = 1'b1;
  endtask

  task automatic wait_frame(input string name);
    int start_cnt;
    int n;
    start_cnt = frames_done;
    n = 0;
    while (frames_done == start_cnt && n < FRAME_BUDGET) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(frames_done - start_cnt), 32'd1);
  endtask

  task automatic check_got(input string name, input logic [7:0] e [FRAME_LEN]);
    check({name, "_len"}, 32'(got_q.size()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < got_q.size()) check(name, 32'(got_q[i]), 32'(e[i]));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},       32'(addr),       32'd0);
    check({tag, "_adc_start"},  32'(adc_start),  32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_data"},    32'(wr_data),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_to_err"},     32'(to_err),     32'd0);
  endtask

  initial begin
    logic [7:0] nom [FRAME_LEN];
    logic [7:0] tmo [FRAME_LEN];
    int         n;
    bit         found;
    nom = '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    tmo = '{8'hAA, 8'h55, 8'h12, 8'h34, 8'hFF, 8'h78, 8'hBD};

    #2;
    check_reset("in_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset("idle_after_reset");

    // Nominal frame with a second start edge while busy
    build_frame(-1);
    pulse_flag();
    repeat (20) @(posedge clk);
    #1;
    check("busy_mid_frame", 32'(busy), 32'd1);
    pulse_flag();
    wait_frame("frame_a_done");
    check_got("frame_a", nom);
    repeat (100) @(posedge clk);
    #1;
    check("glitch_ignored_frames", 32'(frames_done), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);
    check("addr_after_frame", 32'(addr), 32'd0);

    // Backpressure in HDR1 and in PUSH of channel 1
    build_frame(-1);
    bp_hdr1_en = 1'b1;
    bp_push_en = 1'b1;
    pulse_flag();
    wait_frame("frame_b_done");
    check_got("frame_b", nom);
    check("bp_hdr1_exercised", 32'(bp_hdr1_en), 32'd0);
    check("bp_push_exercised", 32'(bp_push_en), 32'd0);

    // Timeout on channel 2
    build_frame(2);
    pulse_flag();
    wait_frame("frame_c_done");
    check_got("frame_c", tmo);
    repeat (50) @(posedge clk);
    #1;
    check("to_err_sticky", 32'(to_err), 32'd1);

    // Next start clears to_err
    build_frame(-1);
    pulse_flag();
    repeat (8) @(posedge clk);
    #1;
    check("to_err_cleared_on_start", 32'(to_err), 32'd0);
    wait_frame("frame_d_done");
    check_got("frame_d", nom);

    // Reset during WAIT of channel 1
    build_frame(-1);
    pulse_flag();
    n = 0;
    found = 1'b0;
    while (!found && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
      if (adc_start && addr == 6'd1) found = 1'b1;
    end
    check("reached_ch1_conv", 32'(found), 32'd1);
    @(posedge clk); #1;
    #1 reset_n = 1'b0;
    #1;
    check_reset("async_reset_mid_frame");
    exp_q.delete();
    byte_idx = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // Full frame after the aborted one
    build_frame(-1);
    pulse_flag();
    wait_frame("frame_f_done");
    check_got("frame_f", nom);
    check("total_frames", 32'(frames_done), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
